// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared constants, tag type and segment-count helper for the field multiplier datapath
package csa_pkg;

   // Default operand width and segment width of the BLS12_381 multiplier datapath
   localparam int CSA_BIT_LEN = 96;
   localparam int CSA_SEG_LEN = 24;
   localparam int CSA_TAG_W   = 8;

   // Tag that travels alongside every operand through the multiplier pipeline
   typedef logic [CSA_TAG_W-1:0] csa_tag_t;

   // Number of adder segments, which is also the pipeline depth of the final adder
   function automatic int csa_num_segs(input int bit_len, input int seg_len);
      return bit_len / seg_len;
   endfunction

endpackage

// File: rtl/cpa_segment_stage.sv
// rtl/cpa_segment_stage.sv - one registered segment of the pipelined carry-propagate adder
module cpa_segment_stage
   import csa_pkg::*;
#(
   parameter int SEG_LEN = CSA_SEG_LEN
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [SEG_LEN-1:0] a,
   input  logic [SEG_LEN-1:0] b,
   input  logic               cin,
   output logic [SEG_LEN-1:0] res,
   output logic               cout
);

   // One bit wider than the segment so the top bit is the carry into the next stage
   logic [SEG_LEN:0] sum;

   assign sum = {1'b0, a} + {1'b0, b} + {{SEG_LEN{1'b0}}, cin};

   // Register the segment sum and its carry-out; hold while the pipeline is stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res  <= '0;
         cout <= 1'b0;
      end else if (en) begin
         res  <= sum[SEG_LEN-1:0];
         cout <= sum[SEG_LEN];
      end
   end

endmodule

// File: rtl/csa_tree_final_adder.sv
// rtl/csa_tree_final_adder.sv - segmented pipelined adder resolving the carry-save tree output
module csa_tree_final_adder
   import csa_pkg::*;
#(
   parameter int BIT_LEN = CSA_BIT_LEN,
   parameter int SEG_LEN = CSA_SEG_LEN,
   parameter int TAG_W   = $bits(csa_tag_t)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BIT_LEN-1:0] in_carry,
   input  logic [BIT_LEN-1:0] in_sum,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BIT_LEN-1:0] out_result,
   output logic               out_cout,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int NUM_SEGS = csa_num_segs(BIT_LEN, SEG_LEN);

   if (BIT_LEN % SEG_LEN != 0) begin : g_len_check
      $error("csa_tree_final_adder: BIT_LEN must be a multiple of SEG_LEN");
   end

   // Whole pipeline advances together unless a finished result is waiting on the consumer
   logic                en;
   logic [NUM_SEGS-1:0] vld_q;
   logic [TAG_W-1:0]    tag_q [NUM_SEGS];

   assign en        = !(out_valid && !out_ready);
   assign in_ready  = en;
   assign out_valid = vld_q[NUM_SEGS-1];
   assign out_tag   = tag_q[NUM_SEGS-1];

   // Valid bits and tags shift one stage per enabled cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int k = 0; k < NUM_SEGS; k++) begin
            tag_q[k] <= '0;
         end
      end else if (en) begin
         vld_q[0] <= in_valid;
         tag_q[0] <= in_tag;
         for (int k = 1; k < NUM_SEGS; k++) begin
            vld_q[k] <= vld_q[k-1];
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   for (genvar k = 0; k < NUM_SEGS; k++) begin : g_stage
      // LO is the bit position of this stage's segment; SKW the operand bits still unresolved above it
      localparam int LO  = k * SEG_LEN;
      localparam int SKW = BIT_LEN - (k + 1) * SEG_LEN;

      // Operand bits from this stage's segment upward, as seen at the stage input
      logic [BIT_LEN-LO-1:0] src_c;
      logic [BIT_LEN-LO-1:0] src_s;
      logic                  seg_cin;
      logic [SEG_LEN-1:0]    seg_res;
      logic                  seg_cout;

      if (k == 0) begin : g_src
         assign src_c   = in_carry;
         assign src_s   = in_sum;
         assign seg_cin = 1'b0;
      end else begin : g_src
         assign src_c   = g_stage[k-1].g_skew.skc_q;
         assign src_s   = g_stage[k-1].g_skew.sks_q;
         assign seg_cin = g_stage[k-1].seg_cout;
      end

      cpa_segment_stage #(
         .SEG_LEN (SEG_LEN)
      ) u_seg (
         .clk  (clk),
         .rst  (rst),
         .en   (en),
         .a    (src_c[SEG_LEN-1:0]),
         .b    (src_s[SEG_LEN-1:0]),
         .cin  (seg_cin),
         .res  (seg_res),
         .cout (seg_cout)
      );

      if (k < NUM_SEGS - 1) begin : g_skew
         logic [SKW-1:0] skc_q;
         logic [SKW-1:0] sks_q;

         // Delay the not-yet-added operand segments so they meet their carry one stage later
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               skc_q <= '0;
               sks_q <= '0;
            end else if (en) begin
               skc_q <= src_c[BIT_LEN-LO-1:SEG_LEN];
               sks_q <= src_s[BIT_LEN-LO-1:SEG_LEN];
            end
         end
      end

      if (k > 0) begin : g_dsk
         logic [LO-1:0] dsk_d;
         logic [LO-1:0] dsk_q;

         if (k == 1) begin : g_first
            assign dsk_d = g_stage[0].seg_res;
         end else begin : g_rest
            assign dsk_d = {g_stage[k-1].seg_res, g_stage[k-1].g_dsk.dsk_q};
         end

         // Carry the already-resolved low segments forward so all bits emerge together
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               dsk_q <= '0;
            end else if (en) begin
               dsk_q <= dsk_d;
            end
         end
      end
   end

   if (NUM_SEGS == 1) begin : g_out
      assign out_result = g_stage[0].seg_res;
   end else begin : g_out
      assign out_result = {g_stage[NUM_SEGS-1].seg_res, g_stage[NUM_SEGS-1].g_dsk.dsk_q};
   end

   assign out_cout = g_stage[NUM_SEGS-1].seg_cout;

endmodule

// File: tb/tb_csa_tree_final_adder.sv
// tb/tb_csa_tree_final_adder.sv - self-checking bench for the pipelined final adder
module tb_csa_tree_final_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [95:0] in_carry = '0;
   logic [95:0] in_sum = '0;
   logic [7:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [95:0] out_result;
   logic        out_cout;
   logic [7:0]  out_tag;

   typedef struct {
      logic [95:0] res;
      logic        cout;
      logic [7:0]  tag;
   } item_t;

   item_t exp_q[$];
   item_t obs_q[$];
   item_t mon_e;
   item_t mon_o;
   logic [96:0] mon_s;

   int n_checks = 0;
   int n_fail = 0;

   csa_tree_final_adder dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_carry   (in_carry),
      .in_sum     (in_sum),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_cout   (out_cout),
      .out_tag    (out_tag)
   );

   always #5 clk = ~clk;

   // Inputs change just after the rising edge, so the falling edge sees settled handshakes
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) begin
            mon_s = {1'b0, in_carry} + {1'b0, in_sum};
            mon_e.res = mon_s[95:0];
            mon_e.cout = mon_s[96];
            mon_e.tag = in_tag;
            exp_q.push_back(mon_e);
         end
         if (out_valid && out_ready) begin
            mon_o.res = out_result;
            mon_o.cout = out_cout;
            mon_o.tag = out_tag;
            obs_q.push_back(mon_o);
         end
      end
   end

   task automatic test_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      n_checks++;
      if (out_result !== 96'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", out_result); end
      n_checks++;
      if (out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", out_cout); end
      n_checks++;
      if (out_tag !== 8'h00) begin n_fail++; $display("FAIL reset_tag: got %h expected 00", out_tag); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_after: got %b expected 0", out_valid); end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_ripple();
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_carry = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
      in_sum = 96'h1;
      in_tag = 8'h5A;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i < 4) begin
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ripple_early_valid cycle %0d: got %b expected 0", i, out_valid); end
         end else begin
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ripple_valid: got %b expected 1", out_valid); end
            n_checks++;
            if (out_result !== 96'h0) begin n_fail++; $display("FAIL ripple_result: got %h expected 0", out_result); end
            n_checks++;
            if (out_cout !== 1'b1) begin n_fail++; $display("FAIL ripple_cout: got %b expected 1", out_cout); end
            n_checks++;
            if (out_tag !== 8'h5A) begin n_fail++; $display("FAIL ripple_tag: got %h expected 5a", out_tag); end
         end
      end
      @(posedge clk); #1;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_throughput();
      logic [95:0] tc [4];
      logic [95:0] ts [4];
      logic [95:0] tr [4];
      logic        tco [4];
      int n;
      int first;
      tc = '{96'd1, 96'd3, 96'd10, {1'b1, 95'b0}};
      ts = '{96'd2, 96'd4, 96'd20, {1'b1, 95'b0}};
      tr = '{96'd3, 96'd7, 96'd30, 96'd0};
      tco = '{1'b0, 1'b0, 1'b0, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_carry = tc[i];
         in_sum = ts[i];
         in_tag = 8'(i);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      first = -1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (first < 0) first = cyc;
            if (n < 4) begin
               n_checks++;
               if (cyc != first + n) begin n_fail++; $display("FAIL thru_gap result %0d: got cycle %0d expected %0d", n, cyc, first + n); end
               n_checks++;
               if (out_result !== tr[n] || out_cout !== tco[n] || out_tag !== 8'(n)) begin
                  n_fail++;
                  $display("FAIL thru_data %0d: got %b/%h/%h expected %b/%h/%h", n, out_cout, out_result, out_tag, tco[n], tr[n], 8'(n));
               end
            end
            n++;
         end
      end
      n_checks++;
      if (n != 4) begin n_fail++; $display("FAIL thru_count: got %0d expected 4", n); end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_backpressure();
      logic [95:0] bc [6];
      logic [95:0] bs [6];
      logic [96:0] bx;
      item_t o;
      exp_q.delete();
      obs_q.delete();
      for (int i = 0; i < 6; i++) begin
         bc[i] = {32'hDEAD_0000 + 32'(i), 64'hFFFF_FFFF_FFFF_FFF0};
         bs[i] = 96'h20 + 96'(i);
      end
      bx = {1'b0, bc[0]} + {1'b0, bs[0]};
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_carry = bc[i];
         in_sum = bs[i];
         in_tag = 8'h10 + 8'(i);
      end
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         n_checks++;
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready stall %0d: got %b expected 0", s, in_ready); end
         n_checks++;
         if (out_valid !== 1'b1 || out_result !== bx[95:0] || out_tag !== 8'h10) begin
            n_fail++;
            $display("FAIL bp_hold stall %0d: got %b/%h/%h expected 1/%h/10", s, out_valid, out_result, out_tag, bx[95:0]);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_carry = bc[5];
      in_sum = bs[5];
      in_tag = 8'h15;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int w = 0; w < 20; w++) @(negedge clk);
      n_checks++;
      if (obs_q.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d expected 6", obs_q.size()); end
      for (int i = 0; i < 6 && obs_q.size() > 0; i++) begin
         o = obs_q.pop_front();
         bx = {1'b0, bc[i]} + {1'b0, bs[i]};
         n_checks++;
         if (o.res !== bx[95:0] || o.cout !== bx[96] || o.tag !== 8'h10 + 8'(i)) begin
            n_fail++;
            $display("FAIL bp_data %0d: got %b/%h/%h expected %b/%h/%h", i, o.cout, o.res, o.tag, bx[96], bx[95:0], 8'h10 + 8'(i));
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset_midflight();
      int stray;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_carry = 96'(7 * (i + 1));
         in_sum = 96'(100 + i);
         in_tag = 8'hA0 + 8'(i);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      stray = 0;
      for (int w = 0; w < 8; w++) begin
         @(negedge clk);
         if (w == 0) begin
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
         end
         if (out_valid !== 1'b0) stray++;
      end
      n_checks++;
      if (stray != 0) begin n_fail++; $display("FAIL midrst_stray_valid: got %0d pulses expected 0", stray); end
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_carry = 96'd5;
      in_sum = 96'd6;
      in_tag = 8'hC3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i < 4) begin
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_early_valid cycle %0d: got %b expected 0", i, out_valid); end
         end else begin
            n_checks++;
            if (out_valid !== 1'b1 || out_result !== 96'd11 || out_cout !== 1'b0 || out_tag !== 8'hC3) begin
               n_fail++;
               $display("FAIL midrst_result: got %b/%b/%h/%h expected 1/0/%h/c3", out_valid, out_cout, out_result, out_tag, 96'd11);
            end
         end
      end
      @(posedge clk); #1;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_random();
      int sent;
      int cycles;
      int compared;
      logic accepted;
      item_t o;
      item_t e;
      sent = 0;
      cycles = 0;
      compared = 0;
      accepted = 1'b0;
      exp_q.delete();
      obs_q.delete();
      while (sent < 10000 && cycles < 60000) begin
         @(posedge clk); #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid || accepted) begin
            if ($urandom_range(0, 3) != 0) begin
               in_valid = 1'b1;
               in_carry = {$urandom, $urandom, $urandom};
               in_sum = {$urandom, $urandom, $urandom};
               if ($urandom_range(0, 7) == 0) in_sum = ~in_carry + 96'($urandom_range(0, 2));
               in_tag = 8'($urandom);
            end else begin
               in_valid = 1'b0;
            end
         end
         @(negedge clk);
         accepted = in_valid && in_ready;
         if (accepted) sent++;
         cycles++;
         while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rand_unexpected: got %h/%h expected no output", o.res, o.tag);
            end else begin
               e = exp_q.pop_front();
               compared++;
               if (o.res !== e.res || o.cout !== e.cout || o.tag !== e.tag) begin
                  n_fail++;
                  $display("FAIL rand_data %0d: got %b/%h/%h expected %b/%h/%h", compared, o.cout, o.res, o.tag, e.cout, e.res, e.tag);
               end
            end
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int w = 0; w < 200 && exp_q.size() > 0; w++) begin
         @(negedge clk);
         while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            compared++;
            n_checks++;
            if (o.res !== e.res || o.cout !== e.cout || o.tag !== e.tag) begin
               n_fail++;
               $display("FAIL rand_data %0d: got %b/%h/%h expected %b/%h/%h", compared, o.cout, o.res, o.tag, e.cout, e.res, e.tag);
            end
         end
      end
      n_checks++;
      if (sent != 10000) begin n_fail++; $display("FAIL rand_sent: got %0d expected 10000", sent); end
      n_checks++;
      if (exp_q.size() != 0 || obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL rand_drain: got %0d pending/%0d extra expected 0/0", exp_q.size(), obs_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_ripple();
      test_throughput();
      test_backpressure();
      test_reset();
      test_reset_midflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
